// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, IF/ID delivery and
// branch redirect. The master modport is the fetch queue side.
interface instr_fetch_queue_if #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               if_valid;
   logic [ADDR_W-1:0]  if_pc;
   logic [INSTR_W-1:0] if_instr;
   logic               id_ready;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;

   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_instr,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_instr,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetch queue: owns the fetch PC, keeps one memory request in flight and
// buffers returned {PC, instruction} pairs for IF/ID; redirects flush it.
module instr_fetch_queue #(
   parameter int unsigned        DEPTH    = 4,
   parameter int unsigned        ADDR_W   = 64,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input logic                  clk,
   input logic                  reset,
   instr_fetch_queue_if.master  bus
);
   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               req_q, req_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  pc_mem_q  [DEPTH];
   logic [INSTR_W-1:0] ins_mem_q [DEPTH];
   logic               push, pop;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      req_d      = req_q;
      push       = 1'b0;
      pop        = 1'b0;
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
         req_d      = 1'b0;
         case (state_q)
            // A grant with a same-cycle response leaves nothing in flight to drain
            REQ:     state_d = (bus.imem_gnt && !bus.imem_rvalid) ? DRAIN : IDLE;
            WAIT:    state_d = bus.imem_rvalid ? IDLE : DRAIN;
            DRAIN:   state_d = bus.imem_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
         endcase
      end else begin
         pop = (count_q != '0) && bus.id_ready;
         case (state_q)
            IDLE: begin
               if (count_q < DEPTH_C) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_q;
               end
            end
            REQ: begin
               if (bus.imem_gnt) begin
                  req_d      = 1'b0;
                  fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                  if (bus.imem_rvalid) begin
                     push    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end
            DRAIN: begin
               if (bus.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (bus.redirect_valid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_q[PTR_W'(i)]  <= '0;
            ins_mem_q[PTR_W'(i)] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push) begin
            pc_mem_q[wr_ptr_q]  <= addr_q;
            ins_mem_q[wr_ptr_q] <= bus.imem_rdata;
         end
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.if_valid  = (count_q != '0);
   assign bus.if_pc     = pc_mem_q[rd_ptr_q];
   assign bus.if_instr  = ins_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model compared every
// cycle, a scripted instruction memory, and directed scenarios.
module tb_instr_fetch_queue;
   localparam int unsigned       DEPTH = 4;
   localparam int unsigned       AW    = 64;
   localparam int unsigned       IW    = 32;
   localparam logic [AW-1:0]     RPC   = '0;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] ins;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   instr_fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   instr_fetch_queue #(
      .DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // memory controls and logs
   bit            gnt_en = 1'b0;
   int            lat    = 1;
   logic [AW-1:0] glog[$];
   ent_t          plog[$];

   // reference model
   ent_t          mq[$];
   logic [AW-1:0] m_fpc, m_addr;
   bit            m_req, m_out, m_drop;

   function automatic logic [IW-1:0] ins_of(input logic [AW-1:0] a);
      return 32'h0000_0013 ^ {a[23:0], 8'h5A};
   endfunction

   function automatic logic [AW-1:0] gat(input int i);
      return (i < glog.size()) ? glog[i] : 64'hDEAD;
   endfunction

   function automatic logic [AW-1:0] pat(input int i);
      return (i < plog.size()) ? plog[i].pc : 64'hDEAD;
   endfunction

   function automatic logic [IW-1:0] iat(input int i);
      return (i < plog.size()) ? plog[i].ins : 32'hDEAD;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Memory: grants when enabled and idle, answers lat cycles after the grant
   initial begin
      bit            pend;
      bit            busy;
      logic [AW-1:0] pend_addr;
      int            pend_cnt;
      pend = 1'b0;
      pend_addr = '0;
      pend_cnt = 0;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         busy = pend;
         bus.imem_gnt = 1'b0;
         bus.imem_rvalid = 1'b0;
         if (pend) begin
            if (pend_cnt == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata = ins_of(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (gnt_en && bus.imem_req && !busy) begin
            bus.imem_gnt = 1'b1;
            glog.push_back(bus.imem_addr);
            if (lat == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata = ins_of(bus.imem_addr);
            end else begin
               pend = 1'b1;
               pend_addr = bus.imem_addr;
               pend_cnt = lat - 1;
            end
         end
      end
   end

   task automatic model_step();
      bit            g, rv, rdy;
      logic [IW-1:0] dat;
      int            n;
      g   = bus.imem_gnt;
      rv  = bus.imem_rvalid;
      rdy = bus.id_ready;
      dat = bus.imem_rdata;
      n   = mq.size();
      if (reset) begin
         mq.delete();
         m_fpc = RPC; m_addr = RPC;
         m_req = 1'b0; m_out = 1'b0; m_drop = 1'b0;
      end else if (bus.redirect_valid) begin
         mq.delete();
         m_fpc = bus.redirect_pc & ~64'd3;
         if (m_req) begin
            m_req = 1'b0;
            if (g && !rv) begin m_out = 1'b1; m_drop = 1'b1; end
         end else if (m_out) begin
            if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
         end
      end else begin
         if (n > 0 && rdy) plog.push_back(mq.pop_front());
         if (m_req) begin
            if (g) begin
               m_req = 1'b0;
               m_fpc = m_fpc + 64'd4;
               if (rv) mq.push_back('{m_addr, dat});
               else m_out = 1'b1;
            end
         end else if (m_out) begin
            if (rv) begin
               if (!m_drop) mq.push_back('{m_addr, dat});
               m_out = 1'b0; m_drop = 1'b0;
            end
         end else if (n < DEPTH) begin
            m_req = 1'b1;
            m_addr = m_fpc;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", bus.imem_req, m_req);
         chk("imem_addr", bus.imem_addr, m_addr);
         chk("if_valid", bus.if_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("if_pc", bus.if_pc, mq[0].pc);
            chk("if_instr", bus.if_instr, mq[0].ins);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      tick();
      reset = 1'b0;
      glog.delete();
      plog.delete();
   endtask

   task automatic wait_grants(input int n, input int lim);
      int c;
      c = 0;
      while (glog.size() < n && c < lim) begin tick(); c++; end
      if (glog.size() < n) chk("grant_timeout", glog.size(), n);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   bus.imem_req,  1'b0);
      chk({tag, "_addr"},  bus.imem_addr, 64'h0);
      chk({tag, "_valid"}, bus.if_valid,  1'b0);
      chk({tag, "_pc"},    bus.if_pc,     64'h0);
      chk({tag, "_instr"}, bus.if_instr,  32'h0);
   endtask

   initial begin
      int rv_c, v_c, c, n, pn;
      reset = 1'b1;
      bus.id_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      tick();
      tick();
      chk_en = 1'b1;
      reset = 1'b0;
      chk_reset_outputs("rst");

      // free run: gnt immediate, rvalid one cycle later
      glog.delete(); plog.delete();
      gnt_en = 1'b1; lat = 1; bus.id_ready = 1'b1;
      rv_c = -1; v_c = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rv_c < 0 && bus.imem_rvalid) rv_c = i;
         if (v_c < 0 && bus.if_valid) v_c = i;
      end
      chk("t1_addr0", gat(0), 64'h0);
      chk("t1_addr1", gat(1), 64'h4);
      chk("t1_addr2", gat(2), 64'h8);
      chk("t1_addr3", gat(3), 64'hC);
      chk("t1_pop_pc0", pat(0), 64'h0);
      chk("t1_pop_pc1", pat(1), 64'h4);
      chk("t1_pop_pc2", pat(2), 64'h8);
      chk("t1_pop_ins0", iat(0), 32'h0000_0049);
      chk("t1_pop_ins2", iat(2), 32'h0000_0849);
      chk("t1_first_valid_lat", v_c - rv_c, 1);

      // fill and stall
      bus.id_ready = 1'b0;
      do_reset();
      ticks(30);
      chk("t2_pushes", glog.size(), 4);
      chk("t2_last_addr", gat(3), 64'hC);
      chk("t2_req_idle", bus.imem_req, 1'b0);
      chk("t2_head_pc", bus.if_pc, 64'h0);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      ticks(8);
      chk("t2_pop_cnt", plog.size(), 1);
      chk("t2_pop_pc", pat(0), 64'h0);
      chk("t2_new_req", gat(4), 64'h10);
      chk("t2_req_cnt", glog.size(), 5);

      // redirect while waiting for a response
      bus.id_ready = 1'b1;
      do_reset();
      lat = 3;
      wait_grants(1, 20);
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 64'h40;
      tick();
      bus.redirect_valid = 1'b0;
      chk("t3_valid_flushed", bus.if_valid, 1'b0);
      wait_grants(2, 20);
      ticks(8);
      chk("t3_next_addr", gat(1), 64'h40);
      chk("t3_pop_pc", pat(0), 64'h40);
      chk("t3_pop_ins", iat(0), 32'h0000_4049);

      // misaligned redirect while the request is not granted
      gnt_en = 1'b0; lat = 1;
      do_reset();
      c = 0;
      while (!bus.imem_req && c < 10) begin tick(); c++; end
      chk("t4_req_up", bus.imem_req, 1'b1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 64'h46;
      tick();
      bus.redirect_valid = 1'b0;
      chk("t4_req_drop", bus.imem_req, 1'b0);
      gnt_en = 1'b1;
      wait_grants(1, 20);
      ticks(6);
      chk("t4_first_grant", gat(0), 64'h44);
      chk("t4_pop_pc", pat(0), 64'h44);
      chk("t4_pop_ins", iat(0), 32'h0000_4449);

      // push and pop together at count=2, then redirect with a pop
      bus.id_ready = 1'b0;
      do_reset();
      c = 0;
      while (mq.size() != 2 && c < 30) begin tick(); c++; end
      chk("t5_fill2", mq.size(), 2);
      c = 0;
      while (!bus.imem_rvalid && c < 20) begin tick(); c++; end
      chk("t5_rvalid_seen", bus.imem_rvalid, 1'b1);
      bus.id_ready = 1'b1;
      tick();
      chk("t5_model_cnt", mq.size(), 2);
      chk("t5_pop_pc", pat(0), 64'h0);
      chk("t5_head_pc", bus.if_pc, 64'h4);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 64'h80;
      tick();
      bus.redirect_valid = 1'b0;
      chk("t5_flush_valid", bus.if_valid, 1'b0);
      chk("t5_pop_ignored", plog.size(), 1);
      n = glog.size();
      wait_grants(n + 1, 20);
      ticks(6);
      chk("t5_redir_addr", gat(n), 64'h80);
      chk("t5_next_pop", pat(1), 64'h80);

      // reset while a response is pending
      do_reset();
      lat = 1;
      wait_grants(2, 20);
      lat = 3;
      wait_grants(3, 20);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_outputs("t6");
      n = glog.size();
      pn = plog.size();
      wait_grants(n + 1, 20);
      ticks(10);
      chk("t6_restart_addr", gat(n), 64'h0);
      chk("t6_restart_pop_pc", pat(pn), 64'h0);
      chk("t6_restart_pop_ins", iat(pn), 32'h0000_0049);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
